// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags; head is offered combinationally, grant marks busy the same cycle.
// Frees are dropped (sticky Overflow_OUT) only when full without a same-cycle grant; Recover_IN rebuilds over NUM_PHYS_REGS cycles.
module phys_reg_free_list #(
  parameter  int NUM_PHYS_REGS = 64,
  parameter  int NUM_ARCH_REGS = 32,
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     Alloc_IN,
  output logic [LOG_PHYS-1:0]      AllocReg_OUT,
  output logic                     AllocValid_OUT,
  input  logic                     Free_IN,
  input  logic [LOG_PHYS-1:0]      FreeReg_IN,
  input  logic                     Recover_IN,
  input  logic [NUM_PHYS_REGS-1:0] InUse_IN,
  output logic                     SetBusy_OUT,
  output logic [LOG_PHYS-1:0]      BusyReg_OUT,
  output logic [LOG_PHYS:0]        FreeCount_OUT,
  output logic                     Rebuilding_OUT,
  output logic                     Overflow_OUT
);

  localparam int QUEUE_W   = NUM_PHYS_REGS * LOG_PHYS;
  localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  typedef enum logic {RUN, REBUILD} state_t;

  // Registers above the architectural set start out free, in ascending order.
  function automatic logic [QUEUE_W-1:0] initQueue();
    logic [QUEUE_W-1:0] q;
    q = '0;
    for (int i = 0; i < INIT_FREE; i++)
      q[i*LOG_PHYS +: LOG_PHYS] = LOG_PHYS'(NUM_ARCH_REGS + i);
    return q;
  endfunction

  localparam logic [QUEUE_W-1:0] QUEUE_INIT = initQueue();

  state_t                   state;
  logic [QUEUE_W-1:0]       queue;
  logic [LOG_PHYS-1:0]      head;
  logic [LOG_PHYS-1:0]      tail;
  logic [LOG_PHYS-1:0]      scanIdx;
  logic [LOG_PHYS:0]        count;
  logic [NUM_PHYS_REGS-1:0] inUseMask;
  logic                     overflow;

  logic                     allocValid;
  logic                     grant;
  logic                     full;
  logic                     pushEn;
  logic [LOG_PHYS-1:0]      pushReg;
  logic                     dropFree;

  always_comb begin
    allocValid = (state == RUN) && (count != '0);
    grant      = Alloc_IN && allocValid && !Recover_IN;
    full       = (count == (LOG_PHYS+1)'(NUM_PHYS_REGS));
    pushEn     = 1'b0;
    pushReg    = FreeReg_IN;
    dropFree   = 1'b0;
    // A full list still takes a free when the head slot is vacated this cycle.
    if (!Recover_IN) begin
      if (state == RUN) begin
        pushEn   = Free_IN && (!full || grant);
        dropFree = Free_IN && full && !grant;
      end else begin
        pushEn  = !inUseMask[scanIdx];
        pushReg = scanIdx;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= RUN;
      queue     <= QUEUE_INIT;
      head      <= '0;
      tail      <= LOG_PHYS'(INIT_FREE);
      count     <= (LOG_PHYS+1)'(INIT_FREE);
      scanIdx   <= '0;
      inUseMask <= '0;
      overflow  <= 1'b0;
    end else if (Recover_IN) begin
      state     <= REBUILD;
      inUseMask <= InUse_IN;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      scanIdx   <= '0;
    end else begin
      if (pushEn) begin
        queue[tail*LOG_PHYS +: LOG_PHYS] <= pushReg;
        tail <= tail + 1'b1;
      end
      if (grant)
        head <= head + 1'b1;
      if (pushEn && !grant)
        count <= count + 1'b1;
      else if (grant && !pushEn)
        count <= count - 1'b1;
      if (dropFree)
        overflow <= 1'b1;
      if (state == REBUILD) begin
        scanIdx <= scanIdx + 1'b1;
        if (scanIdx == LOG_PHYS'(NUM_PHYS_REGS - 1))
          state <= RUN;
      end
    end
  end

  assign AllocReg_OUT   = queue[head*LOG_PHYS +: LOG_PHYS];
  assign AllocValid_OUT = allocValid;
  assign SetBusy_OUT    = grant;
  assign BusyReg_OUT    = AllocReg_OUT;
  assign FreeCount_OUT  = count;
  assign Rebuilding_OUT = (state == REBUILD);
  assign Overflow_OUT   = overflow;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: vector table plus hand-written multi-cycle sequences.
module tb_phys_reg_free_list;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int LP = 6;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          Alloc_IN;
  logic [LP-1:0] AllocReg_OUT;
  logic          AllocValid_OUT;
  logic          Free_IN;
  logic [LP-1:0] FreeReg_IN;
  logic          Recover_IN;
  logic [NP-1:0] InUse_IN;
  logic          SetBusy_OUT;
  logic [LP-1:0] BusyReg_OUT;
  logic [LP:0]   FreeCount_OUT;
  logic          Rebuilding_OUT;
  logic          Overflow_OUT;

  phys_reg_free_list #(.NUM_PHYS_REGS(NP), .NUM_ARCH_REGS(NA)) dut (
    .CLK(CLK), .RESET(RESET),
    .Alloc_IN(Alloc_IN), .AllocReg_OUT(AllocReg_OUT), .AllocValid_OUT(AllocValid_OUT),
    .Free_IN(Free_IN), .FreeReg_IN(FreeReg_IN),
    .Recover_IN(Recover_IN), .InUse_IN(InUse_IN),
    .SetBusy_OUT(SetBusy_OUT), .BusyReg_OUT(BusyReg_OUT),
    .FreeCount_OUT(FreeCount_OUT), .Rebuilding_OUT(Rebuilding_OUT), .Overflow_OUT(Overflow_OUT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic alloc;
    logic free;
    int   freeReg;
    int   expReg;
    logic expValid;
    logic expBusy;
    int   expCount;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    Alloc_IN   = 1'b0;
    Free_IN    = 1'b0;
    FreeReg_IN = '0;
    Recover_IN = 1'b0;
    InUse_IN   = '0;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    idleInputs();
    RESET = 1'b1;
    nextCycle();
    nextCycle();
    RESET = 1'b0;
  endtask

  initial begin
    logic [NP-1:0] low40;
    int            p;
    int            expR;

    //          alloc free reg  expReg valid busy count
    vecs[0] = '{1'b0, 1'b0, 0, 32, 1'b1, 1'b0, 32};
    vecs[1] = '{1'b1, 1'b0, 0, 32, 1'b1, 1'b1, 32};
    vecs[2] = '{1'b1, 1'b0, 0, 33, 1'b1, 1'b1, 31};
    vecs[3] = '{1'b1, 1'b0, 0, 34, 1'b1, 1'b1, 30};
    vecs[4] = '{1'b0, 1'b0, 0, 35, 1'b1, 1'b0, 29};
    vecs[5] = '{1'b1, 1'b1, 3, 35, 1'b1, 1'b1, 29};
    vecs[6] = '{1'b0, 1'b1, 9, 36, 1'b1, 1'b0, 29};
    vecs[7] = '{1'b0, 1'b0, 0, 36, 1'b1, 1'b0, 30};
    vecs[8] = '{1'b1, 1'b0, 0, 36, 1'b1, 1'b1, 30};
    vecs[9] = '{1'b0, 1'b0, 0, 37, 1'b1, 1'b0, 29};

    low40 = '0;
    for (int i = 0; i < 40; i++) low40[i] = 1'b1;

    // Reset state and basic allocate/free vectors
    doReset();
    @(negedge CLK);
    chk("rst.rebuild", Rebuilding_OUT, 0);
    chk("rst.ovf", Overflow_OUT, 0);
    nextCycle();
    doReset();
    for (int i = 0; i < 10; i++) begin
      Alloc_IN   = vecs[i].alloc;
      Free_IN    = vecs[i].free;
      FreeReg_IN = LP'(vecs[i].freeReg);
      @(negedge CLK);
      chk($sformatf("v%0d.reg", i), AllocReg_OUT, vecs[i].expReg);
      chk($sformatf("v%0d.valid", i), AllocValid_OUT, vecs[i].expValid);
      chk($sformatf("v%0d.setbusy", i), SetBusy_OUT, vecs[i].expBusy);
      chk($sformatf("v%0d.busyreg", i), BusyReg_OUT, vecs[i].expReg);
      chk($sformatf("v%0d.count", i), FreeCount_OUT, vecs[i].expCount);
      chk($sformatf("v%0d.rebuild", i), Rebuilding_OUT, 0);
      nextCycle();
    end
    idleInputs();

    // Drain all, allocate from empty, then free into empty
    doReset();
    for (int i = 0; i < 32; i++) begin
      Alloc_IN = 1'b1;
      @(negedge CLK);
      chk($sformatf("drain%0d.setbusy", i), SetBusy_OUT, 1);
      chk($sformatf("drain%0d.busyreg", i), BusyReg_OUT, 32 + i);
      chk($sformatf("drain%0d.count", i), FreeCount_OUT, 32 - i);
      nextCycle();
    end
    @(negedge CLK);
    chk("empty.valid", AllocValid_OUT, 0);
    chk("empty.setbusy", SetBusy_OUT, 0);
    chk("empty.count", FreeCount_OUT, 0);
    nextCycle();
    Free_IN    = 1'b1;
    FreeReg_IN = LP'(5);
    @(negedge CLK);
    chk("freeEmpty.sameValid", AllocValid_OUT, 0);
    chk("freeEmpty.sameBusy", SetBusy_OUT, 0);
    nextCycle();
    idleInputs();
    @(negedge CLK);
    chk("freeEmpty.nextValid", AllocValid_OUT, 1);
    chk("freeEmpty.nextReg", AllocReg_OUT, 5);
    chk("freeEmpty.nextCount", FreeCount_OUT, 1);
    nextCycle();

    // Simultaneous alloc+free of reg 7: count holds, 7 reappears after 32 grants
    doReset();
    for (int k = 0; k < 40; k++) begin
      Alloc_IN   = 1'b1;
      Free_IN    = 1'b1;
      FreeReg_IN = LP'(7);
      @(negedge CLK);
      chk($sformatf("steady%0d.reg", k), AllocReg_OUT, (k < 32) ? 32 + k : 7);
      chk($sformatf("steady%0d.setbusy", k), SetBusy_OUT, 1);
      chk($sformatf("steady%0d.count", k), FreeCount_OUT, 32);
      nextCycle();
    end
    idleInputs();
    @(negedge CLK);
    chk("steady.endCount", FreeCount_OUT, 32);
    nextCycle();

    // Fill to full, dropped free sets overflow, free with grant accepted
    doReset();
    for (int i = 0; i < 32; i++) begin
      Free_IN    = 1'b1;
      FreeReg_IN = LP'(i);
      @(negedge CLK);
      chk($sformatf("fill%0d.count", i), FreeCount_OUT, 32 + i);
      nextCycle();
    end
    FreeReg_IN = LP'(1);
    @(negedge CLK);
    chk("full.count", FreeCount_OUT, 64);
    chk("full.ovfBefore", Overflow_OUT, 0);
    chk("full.setbusy", SetBusy_OUT, 0);
    nextCycle();
    idleInputs();
    @(negedge CLK);
    chk("drop.ovf", Overflow_OUT, 1);
    chk("drop.count", FreeCount_OUT, 64);
    chk("drop.headKept", AllocReg_OUT, 32);
    nextCycle();
    Alloc_IN   = 1'b1;
    Free_IN    = 1'b1;
    FreeReg_IN = LP'(11);
    @(negedge CLK);
    chk("fullGrant.setbusy", SetBusy_OUT, 1);
    chk("fullGrant.reg", AllocReg_OUT, 32);
    nextCycle();
    Free_IN = 1'b0;
    for (int j = 0; j < 64; j++) begin
      p    = (j + 1) % 64;
      expR = (p == 0) ? 11 : ((p < 32) ? 32 + p : p - 32);
      @(negedge CLK);
      chk($sformatf("wrap%0d.reg", j), AllocReg_OUT, expR);
      chk($sformatf("wrap%0d.count", j), FreeCount_OUT, 64 - j);
      nextCycle();
    end
    idleInputs();
    @(negedge CLK);
    chk("wrap.endCount", FreeCount_OUT, 0);
    chk("wrap.endValid", AllocValid_OUT, 0);
    chk("wrap.ovfSticky", Overflow_OUT, 1);
    nextCycle();

    // Recover with low 40 registers in use
    Recover_IN = 1'b1;
    InUse_IN   = low40;
    @(negedge CLK);
    chk("recover.rebuildBefore", Rebuilding_OUT, 0);
    nextCycle();
    idleInputs();
    Alloc_IN   = 1'b1;
    Free_IN    = 1'b1;
    FreeReg_IN = LP'(2);
    for (int c = 0; c < 64; c++) begin
      @(negedge CLK);
      chk($sformatf("rb%0d.rebuild", c), Rebuilding_OUT, 1);
      chk($sformatf("rb%0d.valid", c), AllocValid_OUT, 0);
      chk($sformatf("rb%0d.setbusy", c), SetBusy_OUT, 0);
      chk($sformatf("rb%0d.count", c), FreeCount_OUT, (c > 40) ? c - 40 : 0);
      nextCycle();
    end
    idleInputs();
    @(negedge CLK);
    chk("rbDone.rebuild", Rebuilding_OUT, 0);
    chk("rbDone.count", FreeCount_OUT, 24);
    chk("rbDone.reg", AllocReg_OUT, 40);
    chk("rbDone.valid", AllocValid_OUT, 1);
    nextCycle();
    Alloc_IN = 1'b1;
    nextCycle();
    idleInputs();
    @(negedge CLK);
    chk("rbDone.nextReg", AllocReg_OUT, 41);
    chk("rbDone.nextCount", FreeCount_OUT, 23);
    nextCycle();

    // Reset pulsed asynchronously at rebuild cycle 10
    Recover_IN = 1'b1;
    InUse_IN   = low40;
    nextCycle();
    idleInputs();
    for (int c = 0; c < 10; c++) nextCycle();
    @(negedge CLK);
    chk("abort.preRebuild", Rebuilding_OUT, 1);
    #1;
    RESET = 1'b1;
    #1;
    chk("abort.reg", AllocReg_OUT, 32);
    chk("abort.count", FreeCount_OUT, 32);
    chk("abort.rebuild", Rebuilding_OUT, 0);
    chk("abort.valid", AllocValid_OUT, 1);
    chk("abort.ovf", Overflow_OUT, 0);
    nextCycle();
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort.afterRebuild", Rebuilding_OUT, 0);
    chk("abort.afterCount", FreeCount_OUT, 32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS_REGS, default 64, number of physical registers (power of two, >= 4).
REQ-002 SHALL have parameter NUM_ARCH_REGS, default 32, count of registers architecturally mapped at reset (< NUM_PHYS_REGS).
REQ-003 SHALL derive LOG_PHYS = clog2(NUM_PHYS_REGS).
REQ-004 SHALL have ports; one clock; reset is asynchronous and active-high:
  CLK  input  1  clock, all state updates on posedge
  RESET  input  1  asynchronous, active-high reset
  Alloc_IN  input  1  rename stage requests one free register
  AllocReg_OUT  output  LOG_PHYS  register offered at list head
  AllocValid_OUT  output  1  offered register is valid
  Free_IN  input  1  commit returns a register
  FreeReg_IN  input  LOG_PHYS  register being returned
  Recover_IN  input  1  start free-list rebuild after flush
  InUse_IN  input  NUM_PHYS_REGS  mask of registers still mapped, sampled with Recover_IN
  SetBusy_OUT  output  1  drives register file busy-set strobe
  BusyReg_OUT  output  LOG_PHYS  register to mark busy
  FreeCount_OUT  output  LOG_PHYS+1  entries currently in list
  Rebuilding_OUT  output  1  high while in REBUILD
  Overflow_OUT  output  1  sticky: free attempted while full

Function
REQ-005 SHALL hold a circular FIFO of NUM_PHYS_REGS entries, LOG_PHYS wide, with head, tail and count registers; head/tail wrap NUM_PHYS_REGS-1 -> 0.
REQ-006 SHALL implement FSM states RUN and REBUILD.
REQ-007 AllocReg_OUT SHALL combinationally equal the entry at head; AllocValid_OUT = (state==RUN) && (count!=0).
REQ-008 Grant = Alloc_IN && AllocValid_OUT; on grant, head increments and count decrements at the next edge.
REQ-009 SetBusy_OUT SHALL equal grant combinationally in the same cycle; BusyReg_OUT = AllocReg_OUT (zero-latency busy marking).
REQ-010 In RUN, Free_IN with count<NUM_PHYS_REGS SHALL write FreeReg_IN at tail, increment tail and count.
REQ-011 Free_IN with count==NUM_PHYS_REGS and no same-cycle grant SHALL be dropped and set Overflow_OUT (cleared only by RESET).
REQ-012 Simultaneous grant and free SHALL both complete; count unchanged; a full list plus grant accepts the free.
REQ-013 Free into an empty list SHALL not be allocatable the same cycle; it is offered the following cycle.
REQ-014 Alloc_IN without AllocValid_OUT SHALL have no effect and SetBusy_OUT stays 0.
REQ-015 Recover_IN (any state) SHALL capture InUse_IN, clear head, tail, count, scan index to 0 and enter REBUILD; Recover_IN has priority over Alloc_IN/Free_IN that cycle.
REQ-016 In REBUILD, each cycle SHALL push scan index if its captured InUse bit is 0, then increment index; after index NUM_PHYS_REGS-1 is processed, return to RUN (exactly NUM_PHYS_REGS cycles).
REQ-017 In REBUILD, Alloc_IN and Free_IN SHALL be ignored; AllocValid_OUT and SetBusy_OUT are 0; Rebuilding_OUT = 1.
REQ-018 FreeCount_OUT SHALL equal count, registered.

Reset
REQ-019 RESET high SHALL asynchronously set state RUN, entry[i] = NUM_ARCH_REGS+i for i < NUM_PHYS_REGS-NUM_ARCH_REGS, head 0, tail and count = NUM_PHYS_REGS-NUM_ARCH_REGS, Overflow_OUT 0, scan index 0.
REQ-020 After reset, outputs SHALL be AllocReg_OUT=NUM_ARCH_REGS, AllocValid_OUT=1, SetBusy_OUT=0, Rebuilding_OUT=0, FreeCount_OUT=NUM_PHYS_REGS-NUM_ARCH_REGS.
REQ-021 RESET asserted mid-REBUILD SHALL abort the rebuild and yield REQ-019 state.

Verification
REQ-022 Reset, Alloc_IN high 3 cycles -> AllocReg_OUT 32,33,34 with SetBusy_OUT=1, BusyReg_OUT matching; FreeCount_OUT 29.
REQ-023 Drain all 32, then Alloc_IN -> AllocValid_OUT=0, SetBusy_OUT=0; Free_IN reg 5 -> next cycle AllocReg_OUT=5, AllocValid_OUT=1.
REQ-024 Count 32, simultaneous alloc and free of reg 7 for 40 cycles -> FreeCount_OUT stays 32; reg 7 reappears after 32 grants (wrap verified).
REQ-025 Fill to 64 via frees, extra Free_IN -> dropped, Overflow_OUT=1, FreeCount_OUT=64; same with grant -> accepted.
REQ-026 Recover_IN with InUse_IN = low 40 bits set -> Rebuilding_OUT=1 for 64 cycles, Alloc_IN ignored, then FreeCount_OUT=24, AllocReg_OUT=40.
REQ-027 RESET pulsed at rebuild cycle 10 -> immediately AllocReg_OUT=32, FreeCount_OUT=32, Rebuilding_OUT=0.
